// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB slave memory block: FSM state encoding,
// default bus widths and a small address-range helper.
// -----------------------------------------------------------------------------
package apb_pkg;

  // Default widths for PWDATA/PRDATA and the local PADDR.
  localparam int APB_DATA_W = 8;
  localparam int APB_ADDR_W = 8;

  // Transfer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACCESS = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_mem_array.sv
// -----------------------------------------------------------------------------
// apb_mem_array
// DEPTH x DATA_W storage with one synchronous write port, one combinational
// read port and an asynchronous clear of every word.
//
// Ports:
//   clk_i    - rising-edge clock
//   rst_i    - asynchronous active-high clear (all words -> 0)
//   we_i     - write enable
//   waddr_i  - write word index
//   wdata_i  - write data
//   raddr_i  - read word index
//   rdata_o  - read data (combinational)
// -----------------------------------------------------------------------------
module apb_mem_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage words: cleared on reset, single write port otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_slave_mem.sv
// -----------------------------------------------------------------------------
// apb_slave_mem
// APB slave fronting a small word memory. A transfer is captured on the edge
// that leaves IDLE (or ACCESS, for back-to-back transfers); the FSM then
// spends one SETUP cycle, WAIT_CYCLES wait cycles and one ACCESS cycle with
// PREADY=1. Out-of-range addresses answer with PSLVERR and never write.
//
// Ports:
//   PCLK    - rising-edge clock
//   PRESET  - asynchronous active-high reset (also clears the memory)
//   PSEL    - slave select
//   PENABLE - access-phase indicator
//   PWRITE  - 1 = write, 0 = read
//   PADDR   - word address
//   PWDATA  - write data
//   PREADY  - transfer complete (ACCESS cycle only)
//   PRDATA  - read data, zero outside a successful read ACCESS cycle
//   PSLVERR - error response (out-of-range address) during ACCESS
//   err_cnt - saturating count of PSLVERR responses
// -----------------------------------------------------------------------------
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int DATA_W      = APB_DATA_W,
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic              PREADY,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PSLVERR,
  output logic [7:0]        err_cnt
);

  localparam int              IDX_W   = $clog2(DEPTH);
  localparam logic [3:0]      WAIT_L  = WAIT_CYCLES[3:0];
  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  apb_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic              addr_ok_s;
  logic              we_s;
  logic [DATA_W-1:0] rd_data_s;

  assign addr_ok_s = ({1'b0, addr_q} < DEPTH_L);
  // Commit happens at the edge that closes the ACCESS cycle.
  assign we_s      = (state_q == ST_ACCESS) && write_q && addr_ok_s;

  apb_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk_i   (PCLK),
    .rst_i   (PRESET),
    .we_i    (we_s),
    .waddr_i (addr_q[IDX_W-1:0]),
    .wdata_i (wdata_q),
    .raddr_i (addr_q[IDX_W-1:0]),
    .rdata_o (rd_data_s)
  );

  // Next-state, wait counter and transfer capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    case (state_q)
      ST_IDLE: begin
        // PENABLE without a preceding setup is ignored here.
        if (PSEL && !PENABLE) begin
          state_d = ST_SETUP;
          addr_d  = PADDR;
          wdata_d = PWDATA;
          write_d = PWRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (!PSEL) begin
          state_d = ST_IDLE;
        end else if (PENABLE) begin
          if (WAIT_L == 4'd0) begin
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_L;
          end
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_WAIT: begin
        if (!PSEL) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          state_d = ST_ACCESS;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACCESS: begin
        // A new setup driven during ACCESS chains straight into SETUP.
        if (PSEL && !PENABLE) begin
          state_d = ST_SETUP;
          addr_d  = PADDR;
          wdata_d = PWDATA;
          write_d = PWRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Response outputs are registered from the next state so they line up
  // exactly with the ACCESS cycle.
  always_comb begin
    pready_d  = (state_d == ST_ACCESS);
    pslverr_d = pready_d && !addr_ok_s;
    if (pready_d && !write_q && addr_ok_s) begin
      prdata_d = rd_data_s;
    end else begin
      prdata_d = {DATA_W{1'b0}};
    end
    if (pslverr_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State, capture and output registers.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= {ADDR_W{1'b0}};
      wdata_q   <= {DATA_W{1'b0}};
      write_q   <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= {DATA_W{1'b0}};
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign PRDATA  = prdata_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_mem
// Self-checking bench: instance A (WAIT_CYCLES=1) exercises directed tables,
// aborts, errors, reset and random traffic against an array reference model;
// instance B (WAIT_CYCLES=0) exercises back-to-back transfers.
// -----------------------------------------------------------------------------
module tb_apb_slave_mem;

  localparam int DEPTH = 64;

  logic       PCLK;
  logic       PRESET;

  logic       psel_a, penable_a, pwrite_a;
  logic [7:0] paddr_a, pwdata_a;
  logic       pready_a, pslverr_a;
  logic [7:0] prdata_a, err_cnt_a;

  logic       psel_b, penable_b, pwrite_b;
  logic [7:0] paddr_b, pwdata_b;
  logic       pready_b, pslverr_b;
  logic [7:0] prdata_b, err_cnt_b;

  int checks   = 0;
  int failures = 0;

  // Reference model: plain word array plus saturating error count.
  logic [7:0] model_mem [DEPTH];
  int         model_err;

  apb_slave_mem #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEPTH), .WAIT_CYCLES(1)) dut_a (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel_a), .PENABLE(penable_a),
    .PWRITE(pwrite_a), .PADDR(paddr_a), .PWDATA(pwdata_a), .PREADY(pready_a),
    .PRDATA(prdata_a), .PSLVERR(pslverr_a), .err_cnt(err_cnt_a)
  );

  apb_slave_mem #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_b (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel_b), .PENABLE(penable_b),
    .PWRITE(pwrite_b), .PADDR(paddr_b), .PWDATA(pwdata_b), .PREADY(pready_b),
    .PRDATA(prdata_b), .PSLVERR(pslverr_b), .err_cnt(err_cnt_b)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    model_err = 0;
  endtask

  // Expected outcome of one transfer, from the address-range rule alone.
  task automatic model_xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                            output logic [7:0] exp_rd, output logic exp_err);
    exp_rd  = 8'h00;
    exp_err = 1'b0;
    if (int'(a) >= DEPTH) begin
      exp_err = 1'b1;
      if (model_err < 255) model_err++;
    end else if (wr) begin
      model_mem[a] = d;
    end else begin
      exp_rd = model_mem[a];
    end
  endtask

  // One isolated transfer on instance A. cyc counts from the SETUP cycle
  // (1) to the cycle PREADY is seen; 99 means PREADY never arrived.
  task automatic xfer_a(input logic wr, input logic [7:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output logic se, output int cyc);
    psel_a = 1'b1; penable_a = 1'b0; pwrite_a = wr; paddr_a = a; pwdata_a = d;
    @(posedge PCLK); #1;
    penable_a = 1'b1;
    // Scramble the bus after capture: the slave must use captured values.
    paddr_a = ~a; pwdata_a = ~d; pwrite_a = ~wr;
    cyc = 1; rd = 8'h00; se = 1'b0;
    while (pready_a !== 1'b1 && cyc < 40) begin
      check("prdata_zero_while_busy", {24'd0, prdata_a}, 32'd0);
      @(posedge PCLK); #1;
      cyc++;
    end
    if (pready_a === 1'b1) begin
      rd = prdata_a; se = pslverr_a;
    end else begin
      cyc = 99;
    end
    psel_a = 1'b0; penable_a = 1'b0;
    @(posedge PCLK); #1;
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } b2b_t;

  vec_t vecs [20];
  b2b_t bops [5];

  initial begin
    logic [7:0] rd, exp_rd;
    logic       se, exp_err;
    int         cyc;

    // Table: 8 writes of 2*i, 8 reads back, then the out-of-range pair.
    for (int i = 0; i < 8; i++) begin
      vecs[i]     = '{1'b1, 8'(i), 8'(2 * i), 8'h00, 1'b0};
      vecs[i + 8] = '{1'b0, 8'(i), 8'h00, 8'(2 * i), 1'b0};
    end
    vecs[16] = '{1'b1, 8'h40, 8'h09, 8'h00, 1'b1};
    vecs[17] = '{1'b0, 8'h40, 8'h00, 8'h00, 1'b1};
    vecs[18] = '{1'b1, 8'h3F, 8'hA5, 8'h00, 1'b0};
    vecs[19] = '{1'b0, 8'h3F, 8'h00, 8'hA5, 1'b0};

    bops[0] = '{1'b1, 8'd10, 8'hA1, 8'h00};
    bops[1] = '{1'b1, 8'd11, 8'hB2, 8'h00};
    bops[2] = '{1'b1, 8'd12, 8'hC3, 8'h00};
    bops[3] = '{1'b0, 8'd12, 8'h00, 8'hC3};
    bops[4] = '{1'b0, 8'd10, 8'h00, 8'hA1};

    PRESET = 1'b1;
    psel_a = 1'b0; penable_a = 1'b0; pwrite_a = 1'b0; paddr_a = 8'h00; pwdata_a = 8'h00;
    psel_b = 1'b0; penable_b = 1'b0; pwrite_b = 1'b0; paddr_b = 8'h00; pwdata_b = 8'h00;
    model_reset();

    // Reset state.
    @(posedge PCLK); #1;
    check("rst_pready",  {31'd0, pready_a},  32'd0);
    check("rst_pslverr", {31'd0, pslverr_a}, 32'd0);
    check("rst_prdata",  {24'd0, prdata_a},  32'd0);
    check("rst_err_cnt", {24'd0, err_cnt_a}, 32'd0);
    PRESET = 1'b0;
    @(posedge PCLK); #1;

    // Stray PENABLE with no setup: no response.
    penable_a = 1'b1;
    repeat (3) begin
      @(posedge PCLK); #1;
      check("stray_penable_pready", {31'd0, pready_a}, 32'd0);
    end
    penable_a = 1'b0;

    // Write 0x0E to 7 then read it: PREADY on cycle 3.
    xfer_a(1'b1, 8'd7, 8'h0E, rd, se, cyc);
    model_xfer(1'b1, 8'd7, 8'h0E, exp_rd, exp_err);
    check("wr7_latency", cyc, 32'd3);
    check("wr7_pslverr", {31'd0, se}, 32'd0);
    xfer_a(1'b0, 8'd7, 8'h00, rd, se, cyc);
    model_xfer(1'b0, 8'd7, 8'h00, exp_rd, exp_err);
    check("rd7_latency", cyc, 32'd3);
    check("rd7_data", {24'd0, rd}, 32'h0E);
    check("rd7_pslverr", {31'd0, se}, 32'd0);

    // PSEL dropped during WAIT of a write of 0x55 to addr 3.
    psel_a = 1'b1; penable_a = 1'b0; pwrite_a = 1'b1; paddr_a = 8'd3; pwdata_a = 8'h55;
    @(posedge PCLK); #1;
    penable_a = 1'b1;
    @(posedge PCLK); #1;
    check("abort_wait_pready", {31'd0, pready_a}, 32'd0);
    psel_a = 1'b0; penable_a = 1'b0;
    repeat (2) begin
      @(posedge PCLK); #1;
      check("abort_after_pready", {31'd0, pready_a}, 32'd0);
    end
    xfer_a(1'b0, 8'd3, 8'h00, rd, se, cyc);
    model_xfer(1'b0, 8'd3, 8'h00, exp_rd, exp_err);
    check("abort_rd3_data", {24'd0, rd}, 32'h00);
    check("abort_err_cnt", {24'd0, err_cnt_a}, 32'd0);

    // Table-driven vectors, including out-of-range and top legal address.
    for (int i = 0; i < 20; i++) begin
      xfer_a(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, se, cyc);
      model_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, exp_rd, exp_err);
      check($sformatf("vec%0d_latency", i), cyc, 32'd3);
      check($sformatf("vec%0d_rdata", i), {24'd0, rd}, {24'd0, vecs[i].exp_rd});
      check($sformatf("vec%0d_pslverr", i), {31'd0, se}, {31'd0, vecs[i].exp_err});
      if (i == 16) check("oor_wr_err_cnt", {24'd0, err_cnt_a}, 32'd1);
      if (i == 17) check("oor_rd_err_cnt", {24'd0, err_cnt_a}, 32'd2);
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 60; n++) begin
      logic       wr;
      logic [7:0] a, d;
      wr = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 79));
      d  = 8'($urandom_range(0, 255));
      xfer_a(wr, a, d, rd, se, cyc);
      model_xfer(wr, a, d, exp_rd, exp_err);
      check("rand_latency", cyc, 32'd3);
      check("rand_rdata", {24'd0, rd}, {24'd0, exp_rd});
      check("rand_pslverr", {31'd0, se}, {31'd0, exp_err});
      check("rand_err_cnt", {24'd0, err_cnt_a}, 32'(model_err));
    end

    // Reset pulsed mid-WAIT after addr 5 was written.
    xfer_a(1'b1, 8'd5, 8'h23, rd, se, cyc);
    model_xfer(1'b1, 8'd5, 8'h23, exp_rd, exp_err);
    psel_a = 1'b1; penable_a = 1'b0; pwrite_a = 1'b1; paddr_a = 8'd9; pwdata_a = 8'h77;
    @(posedge PCLK); #1;
    penable_a = 1'b1;
    @(posedge PCLK); #1;
    check("prerst_err_cnt_nonzero", {31'd0, (err_cnt_a != 8'd0)}, 32'd1);
    #2 PRESET = 1'b1;
    #1;
    check("midrst_pready", {31'd0, pready_a}, 32'd0);
    check("midrst_err_cnt", {24'd0, err_cnt_a}, 32'd0);
    check("midrst_prdata", {24'd0, prdata_a}, 32'd0);
    psel_a = 1'b0; penable_a = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    model_reset();
    @(posedge PCLK); #1;
    xfer_a(1'b0, 8'd5, 8'h00, rd, se, cyc);
    check("postrst_rd5", {24'd0, rd}, 32'h00);
    check("postrst_latency", cyc, 32'd3);
    xfer_a(1'b0, 8'd9, 8'h00, rd, se, cyc);
    check("postrst_rd9", {24'd0, rd}, 32'h00);
    xfer_a(1'b1, 8'd9, 8'h3C, rd, se, cyc);
    xfer_a(1'b0, 8'd9, 8'h00, rd, se, cyc);
    check("postrst_wr_rd9", {24'd0, rd}, 32'h3C);

    // Instance B (no wait states): back-to-back transfers every 2 cycles.
    @(posedge PCLK); #1;
    for (int k = 0; k < 5; k++) begin
      psel_b = 1'b1; penable_b = 1'b0;
      pwrite_b = bops[k].wr; paddr_b = bops[k].addr; pwdata_b = bops[k].wdata;
      @(posedge PCLK); #1;
      check("b2b_setup_pready", {31'd0, pready_b}, 32'd0);
      check("b2b_setup_prdata", {24'd0, prdata_b}, 32'd0);
      penable_b = 1'b1;
      @(posedge PCLK); #1;
      check("b2b_access_pready", {31'd0, pready_b}, 32'd1);
      check("b2b_access_pslverr", {31'd0, pslverr_b}, 32'd0);
      if (!bops[k].wr) check("b2b_rdata", {24'd0, prdata_b}, {24'd0, bops[k].exp_rd});
    end
    psel_b = 1'b0; penable_b = 1'b0;
    @(posedge PCLK); #1;
    check("b2b_end_pready", {31'd0, pready_b}, 32'd0);
    check("b2b_err_cnt", {24'd0, err_cnt_b}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
